// File: rtl/set_assoc_dcache.sv
// set_assoc_dcache
//   N-way set-associative, write-back, write-allocate data cache sitting
//   between the CPU load/store unit and main memory. Serves byte/half/word
//   loads with sign or zero extension and byte/half/word stores. Replacement
//   is true LRU. Whole lines are refilled and evicted over a valid/ready
//   memory port.
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   cpu_valid_i     CPU request, held with all cpu_* inputs until cpu_ready_o
//   cpu_wen_i       1 = store, 0 = load
//   cpu_addr_i      byte address
//   cpu_funct3_i    000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
//   cpu_wdata_i     right-aligned store data
//   cpu_rdata_o     load result while cpu_ready_o=1, holds otherwise
//   cpu_ready_o     one-cycle completion pulse
//   mem_valid_o     line transfer request, held until mem_ready_i
//   mem_wen_o       1 = writeback, 0 = refill
//   mem_addr_o      line-aligned address
//   mem_wdata_o     writeback line
//   mem_rdata_i     refill line, valid with mem_ready_i
//   mem_ready_i     completes the transfer when mem_valid_o is high
module set_assoc_dcache #(
  parameter int ADDR_WIDTH  = 32,
  parameter int WAYS        = 4,
  parameter int SETS        = 8,
  parameter int BLOCK_BYTES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_valid_i,
  input  logic                       cpu_wen_i,
  input  logic [ADDR_WIDTH-1:0]      cpu_addr_i,
  input  logic [2:0]                 cpu_funct3_i,
  input  logic [31:0]                cpu_wdata_i,
  output logic [31:0]                cpu_rdata_o,
  output logic                       cpu_ready_o,
  output logic                       mem_valid_o,
  output logic                       mem_wen_o,
  output logic [ADDR_WIDTH-1:0]      mem_addr_o,
  output logic [8*BLOCK_BYTES-1:0]   mem_wdata_o,
  input  logic [8*BLOCK_BYTES-1:0]   mem_rdata_i,
  input  logic                       mem_ready_i
);

  localparam int OB = $clog2(BLOCK_BYTES);
  localparam int SB = $clog2(SETS);
  localparam int TW = ADDR_WIDTH - OB - SB;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BB = 8 * BLOCK_BYTES;

  if (WAYS < 1 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
    $error("set_assoc_dcache: WAYS must be a power of 2");
  end
  if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
    $error("set_assoc_dcache: SETS must be a power of 2 and at least 2");
  end
  if (BLOCK_BYTES < 4 || (BLOCK_BYTES & (BLOCK_BYTES - 1)) != 0) begin : g_bad_block
    $error("set_assoc_dcache: BLOCK_BYTES must be a power of 2 and at least 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_COMP, S_WB, S_REFILL} state_t;

  state_t state_q, state_d;

  logic                  req_wen_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [2:0]            req_funct3_q;
  logic [31:0]           req_wdata_q;
  logic [WW-1:0]         victim_q;
  logic [31:0]           rdata_q;

  logic          valid_q [WAYS][SETS];
  logic          dirty_q [WAYS][SETS];
  logic [WW-1:0] age_q   [SETS][WAYS];
  logic [TW-1:0] tag_q   [WAYS][SETS];
  logic [BB-1:0] data_q  [WAYS][SETS];

  logic [OB-1:0] req_off;
  logic [SB-1:0] req_set;
  logic [TW-1:0] req_tag;

  assign req_off = req_addr_q[OB-1:0];
  assign req_set = req_addr_q[OB+SB-1:OB];
  assign req_tag = req_addr_q[ADDR_WIDTH-1:OB+SB];

  logic          hit;
  logic [WW-1:0] hit_way;
  logic [WW-1:0] victim_c;
  logic [BB-1:0] hit_line;
  logic [BB-1:0] st_line;
  logic [31:0]   load_val;
  logic [OB+2:0] b_bit, h_bit, w_bit;
  logic [7:0]    lb;
  logic [15:0]   lh;

  // Tag lookup, victim choice and load/store datapath for the latched request.
  // Half and word accesses simply clear the low offset bits, so misaligned
  // addresses wrap onto the containing aligned unit instead of trapping.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    victim_c = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_set] && tag_q[w][req_set] == req_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[req_set][w] == WW'(WAYS - 1)) victim_c = WW'(w);
    end
    // Descending scan so the lowest-index invalid way wins over the LRU way.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][req_set]) victim_c = WW'(w);
    end

    hit_line = data_q[hit_way][req_set];
    b_bit    = {req_off, 3'b000};
    h_bit    = {req_off & ~OB'(1), 3'b000};
    w_bit    = {req_off & ~OB'(3), 3'b000};
    lb       = hit_line[b_bit +: 8];
    lh       = hit_line[h_bit +: 16];

    case (req_funct3_q)
      3'b000:  load_val = {{24{lb[7]}}, lb};
      3'b100:  load_val = {24'b0, lb};
      3'b001:  load_val = {{16{lh[15]}}, lh};
      3'b101:  load_val = {16'b0, lh};
      default: load_val = hit_line[w_bit +: 32];
    endcase

    st_line = hit_line;
    case (req_funct3_q)
      3'b000, 3'b100: st_line[b_bit +: 8]  = req_wdata_q[7:0];
      3'b001, 3'b101: st_line[h_bit +: 16] = req_wdata_q[15:0];
      default:        st_line[w_bit +: 32] = req_wdata_q;
    endcase
  end

  // Next-state and output decode. Memory outputs depend only on state and
  // registered values, so they stay stable while a transfer is stalled.
  always_comb begin
    state_d     = state_q;
    cpu_ready_o = 1'b0;
    cpu_rdata_o = rdata_q;
    mem_valid_o = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      S_IDLE: begin
        if (cpu_valid_i) state_d = S_COMP;
      end
      S_COMP: begin
        if (hit) begin
          cpu_ready_o = 1'b1;
          cpu_rdata_o = req_wen_q ? 32'b0 : load_val;
          state_d     = S_IDLE;
        end else if (valid_q[victim_c][req_set] && dirty_q[victim_c][req_set]) begin
          state_d = S_WB;
        end else begin
          state_d = S_REFILL;
        end
      end
      S_WB: begin
        mem_valid_o = 1'b1;
        mem_wen_o   = 1'b1;
        mem_addr_o  = {tag_q[victim_q][req_set], req_set, {OB{1'b0}}};
        mem_wdata_o = data_q[victim_q][req_set];
        if (mem_ready_i) state_d = S_REFILL;
      end
      S_REFILL: begin
        mem_valid_o = 1'b1;
        mem_addr_o  = {req_tag, req_set, {OB{1'b0}}};
        if (mem_ready_i) state_d = S_COMP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, latched request, line status bits and LRU ages.
  // A reset in the middle of a transfer simply abandons it; every line is
  // invalidated so no partial refill can ever be observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_wen_q    <= 1'b0;
      req_addr_q   <= '0;
      req_funct3_q <= '0;
      req_wdata_q  <= '0;
      victim_q     <= '0;
      rdata_q      <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
          age_q[s][w]   <= WW'(w);
        end
      end
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && cpu_valid_i) begin
        req_wen_q    <= cpu_wen_i;
        req_addr_q   <= cpu_addr_i;
        req_funct3_q <= cpu_funct3_i;
        req_wdata_q  <= cpu_wdata_i;
      end
      if (state_q == S_COMP) begin
        if (hit) begin
          rdata_q <= req_wen_q ? 32'b0 : load_val;
          if (req_wen_q) dirty_q[hit_way][req_set] <= 1'b1;
          // Accessed way becomes MRU; only ways more recent than it age.
          for (int w = 0; w < WAYS; w++) begin
            if (WW'(w) == hit_way) begin
              age_q[req_set][w] <= '0;
            end else if (age_q[req_set][w] < age_q[req_set][hit_way]) begin
              age_q[req_set][w] <= age_q[req_set][w] + 1'b1;
            end
          end
        end else begin
          victim_q <= victim_c;
        end
      end
      if (state_q == S_WB && mem_ready_i) begin
        dirty_q[victim_q][req_set] <= 1'b0;
      end
      if (state_q == S_REFILL && mem_ready_i) begin
        valid_q[victim_q][req_set] <= 1'b1;
        dirty_q[victim_q][req_set] <= 1'b0;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (state_q == S_COMP && hit && req_wen_q) begin
      data_q[hit_way][req_set] <= st_line;
    end
    if (state_q == S_REFILL && mem_ready_i) begin
      data_q[victim_q][req_set] <= mem_rdata_i;
      tag_q[victim_q][req_set]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_set_assoc_dcache.sv
// tb_set_assoc_dcache
//   Self-checking bench for set_assoc_dcache with default parameters.
//   The bench plays main memory and keeps a reference cache model made of
//   per-set recency lists (index 0 = most recent) plus a byte-level line
//   image, from which hit/miss, writeback/refill traffic and load data are
//   predicted.
module tb_set_assoc_dcache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_valid_i;
  logic         cpu_wen_i;
  logic [31:0]  cpu_addr_i;
  logic [2:0]   cpu_funct3_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_ready_o;
  logic         mem_valid_o;
  logic         mem_wen_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [127:0] mem_rdata_i;
  logic         mem_ready_i;

  set_assoc_dcache dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_valid_i  (cpu_valid_i),
    .cpu_wen_i    (cpu_wen_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_funct3_i (cpu_funct3_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_ready_o  (cpu_ready_o),
    .mem_valid_o  (mem_valid_o),
    .mem_wen_o    (mem_wen_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ready_i  (mem_ready_i)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  logic [127:0] mem_model [logic [31:0]];
  logic [31:0]  m_la    [8][4];
  logic [127:0] m_data  [8][4];
  bit           m_dirty [8][4];
  int           m_cnt   [8];

  bit           wb080_seen;
  logic [127:0] wb080_data;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int s = 0; s < 8; s++) m_cnt[s] = 0;
  endtask

  // One CPU access, acting as memory meanwhile, then model update and checks.
  task automatic applyStimulus(input bit wen, input logic [31:0] addr, input logic [2:0] f3,
                               input logic [31:0] wd, input int stall_fix,
                               output logic [31:0] rd, output bit missed);
    int s, pos, n_exp, ops, cycles, stall, size, off, base;
    bit exp_wb, active, done, sgn, cur_wen, ldirty;
    logic [31:0] la, cur_addr, exp_rd;
    logic [127:0] fill, cur_wdata, line;
    s = int'(addr[6:4]);
    la = {addr[31:4], 4'h0};
    pos = -1;
    for (int i = 0; i < m_cnt[s]; i++) if (m_la[s][i] == la) pos = i;
    exp_wb = (pos < 0) && (m_cnt[s] == 4) && m_dirty[s][3];
    n_exp = (pos >= 0) ? 0 : (exp_wb ? 2 : 1);
    if (!mem_model.exists(la)) mem_model[la] = {$urandom, $urandom, $urandom, $urandom};
    fill = mem_model[la];
    rd = '0; ops = 0; active = 0; done = 0; cycles = 0; stall = 0;
    cur_addr = '0; cur_wen = 0; cur_wdata = '0;

    @(negedge clk);
    cpu_valid_i = 1'b1; cpu_wen_i = wen; cpu_addr_i = addr;
    cpu_funct3_i = f3; cpu_wdata_i = wd;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      mem_ready_i = 1'b0;
      if (cpu_ready_o) begin
        done = 1;
        rd = cpu_rdata_o;
        checkOutput("ready_while_mem_pending", active, 0);
      end else if (mem_valid_o) begin
        if (!active) begin
          active = 1;
          cur_addr = mem_addr_o; cur_wen = mem_wen_o; cur_wdata = mem_wdata_o;
          stall = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 3));
          if (exp_wb && ops == 0) begin
            checkOutput("wb_wen", cur_wen, 1);
            checkOutput("wb_addr", cur_addr, m_la[s][3]);
            checkOutput("wb_data", cur_wdata, m_data[s][3]);
          end else begin
            checkOutput("refill_wen", cur_wen, 0);
            checkOutput("refill_addr", cur_addr, la);
          end
          if (cur_wen && cur_addr == 32'h80) begin
            wb080_seen = 1;
            wb080_data = cur_wdata;
          end
        end else begin
          checkOutput("mem_addr_stable", mem_addr_o, cur_addr);
          checkOutput("mem_wen_stable", mem_wen_o, cur_wen);
          checkOutput("mem_wdata_stable", mem_wdata_o, cur_wdata);
        end
        if (stall == 0) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = fill;
          active = 0;
          ops++;
        end else begin
          stall--;
        end
      end
    end
    cpu_valid_i = 1'b0;
    mem_ready_i = 1'b0;
    checkOutput("request_completed", done, 1);
    checkOutput("mem_transfers", ops, n_exp);
    if (pos >= 0) checkOutput("hit_latency", cycles, 1);
    missed = (ops > 0);

    // Reference update: pull the line out of the recency list (or allocate).
    if (pos >= 0) begin
      line = m_data[s][pos];
      ldirty = m_dirty[s][pos];
      for (int i = pos; i < m_cnt[s] - 1; i++) begin
        m_la[s][i] = m_la[s][i+1]; m_data[s][i] = m_data[s][i+1]; m_dirty[s][i] = m_dirty[s][i+1];
      end
      m_cnt[s]--;
    end else begin
      if (m_cnt[s] == 4) begin
        if (m_dirty[s][3]) mem_model[m_la[s][3]] = m_data[s][3];
        m_cnt[s] = 3;
      end
      line = fill;
      ldirty = 0;
    end
    case (f3)
      3'b000: begin size = 1; sgn = 1; end
      3'b100: begin size = 1; sgn = 0; end
      3'b001: begin size = 2; sgn = 1; end
      3'b101: begin size = 2; sgn = 0; end
      default: begin size = 4; sgn = 0; end
    endcase
    off = int'(addr[3:0]);
    base = off - (off % size);
    exp_rd = '0;
    if (wen) begin
      for (int b = 0; b < size; b++) line[(base+b)*8 +: 8] = wd[b*8 +: 8];
      ldirty = 1;
    end else begin
      for (int b = 0; b < size; b++) exp_rd[b*8 +: 8] = line[(base+b)*8 +: 8];
      if (sgn && exp_rd[size*8-1]) for (int b = size; b < 4; b++) exp_rd[b*8 +: 8] = 8'hFF;
    end
    for (int i = m_cnt[s]; i > 0; i--) begin
      m_la[s][i] = m_la[s][i-1]; m_data[s][i] = m_data[s][i-1]; m_dirty[s][i] = m_dirty[s][i-1];
    end
    m_la[s][0] = la; m_data[s][0] = line; m_dirty[s][0] = ldirty;
    m_cnt[s]++;
    checkOutput("rdata", rd, exp_rd);
  endtask

  initial begin
    logic [31:0] rd;
    bit missed, seen;
    logic [31:0] a;

    rst_n = 1'b0;
    cpu_valid_i = 0; cpu_wen_i = 0; cpu_addr_i = '0; cpu_funct3_i = '0; cpu_wdata_i = '0;
    mem_rdata_i = '0; mem_ready_i = 0;
    wb080_seen = 0; wb080_data = '0;
    clearModel();
    repeat (3) @(negedge clk);
    checkOutput("reset_cpu_ready", cpu_ready_o, 0);
    checkOutput("reset_cpu_rdata", cpu_rdata_o, 0);
    checkOutput("reset_mem_valid", mem_valid_o, 0);
    checkOutput("reset_mem_wen", mem_wen_o, 0);
    checkOutput("reset_mem_addr", mem_addr_o, 0);
    checkOutput("reset_mem_wdata", mem_wdata_o, 0);
    rst_n = 1'b1;

    // Line 0x100: word1 = 0x11223344, byte3 = 0x80, half at 0x102 = 0x8001
    mem_model[32'h100] = 128'h0A0B0C0D_01020304_11223344_80015566;
    applyStimulus(0, 32'h100, 3'b010, 0, -1, rd, missed);
    checkOutput("first_load_miss", missed, 1);
    applyStimulus(0, 32'h104, 3'b010, 0, -1, rd, missed);
    checkOutput("lw_0x104_value", rd, 32'h11223344);
    checkOutput("lw_0x104_hit", missed, 0);
    applyStimulus(0, 32'h103, 3'b000, 0, -1, rd, missed);
    checkOutput("lb_sign", rd, 32'hFFFFFF80);
    applyStimulus(0, 32'h103, 3'b100, 0, -1, rd, missed);
    checkOutput("lbu_zero", rd, 32'h00000080);
    applyStimulus(0, 32'h102, 3'b001, 0, -1, rd, missed);
    checkOutput("lh_sign", rd, 32'hFFFF8001);
    applyStimulus(0, 32'h102, 3'b101, 0, -1, rd, missed);
    checkOutput("lhu_zero", rd, 32'h00008001);

    // LRU: 0x200 should displace 0x080, leaving 0x000 resident
    applyStimulus(0, 32'h000, 3'b010, 0, -1, rd, missed);
    applyStimulus(0, 32'h080, 3'b010, 0, -1, rd, missed);
    applyStimulus(0, 32'h100, 3'b010, 0, -1, rd, missed);
    applyStimulus(0, 32'h180, 3'b010, 0, -1, rd, missed);
    applyStimulus(0, 32'h000, 3'b010, 0, -1, rd, missed);
    checkOutput("reload_0x000_hit", missed, 0);
    applyStimulus(0, 32'h200, 3'b010, 0, -1, rd, missed);
    applyStimulus(0, 32'h080, 3'b010, 0, -1, rd, missed);
    checkOutput("lru_0x080_evicted", missed, 1);
    applyStimulus(0, 32'h000, 3'b010, 0, -1, rd, missed);
    checkOutput("lru_0x000_kept", missed, 0);

    // Dirty line 0x080 is written back before its replacement is refilled
    applyStimulus(1, 32'h084, 3'b010, 32'hDEADBEEF, -1, rd, missed);
    checkOutput("sw_0x084_hit", missed, 0);
    applyStimulus(0, 32'h300, 3'b010, 0, -1, rd, missed);
    applyStimulus(0, 32'h380, 3'b010, 0, -1, rd, missed);
    applyStimulus(0, 32'h400, 3'b010, 0, -1, rd, missed);
    applyStimulus(0, 32'h480, 3'b010, 0, -1, rd, missed);
    checkOutput("wb_0x080_seen", wb080_seen, 1);
    checkOutput("wb_0x080_word1", wb080_data[63:32], 32'hDEADBEEF);

    // Refill stalled for 5 cycles
    applyStimulus(0, 32'h510, 3'b010, 0, 5, rd, missed);
    checkOutput("stalled_refill_miss", missed, 1);

    // Randomized traffic concentrated on two sets to force conflicts
    for (int n = 0; n < 250; n++) begin
      a = (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 1)) << 4) | 32'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom, -1, rd, missed);
    end

    // Reset during a refill wait
    applyStimulus(0, 32'h100, 3'b010, 0, -1, rd, missed);
    @(negedge clk);
    cpu_valid_i = 1; cpu_wen_i = 0; cpu_addr_i = 32'h7F00; cpu_funct3_i = 3'b010;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      mem_ready_i = 0;
      if (mem_valid_o && !mem_wen_o) seen = 1;
      else if (mem_valid_o) mem_ready_i = 1;
    end
    checkOutput("refill_wait_reached", seen, 1);
    rst_n = 0;
    cpu_valid_i = 0;
    mem_ready_i = 0;
    #1;
    checkOutput("async_reset_mem_valid", mem_valid_o, 0);
    checkOutput("async_reset_mem_addr", mem_addr_o, 0);
    clearModel();
    @(negedge clk);
    rst_n = 1;
    applyStimulus(0, 32'h104, 3'b010, 0, -1, rd, missed);
    checkOutput("post_reset_0x100_miss", missed, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
